// File: rtl/classificador_cores_quadrante_pkg.sv
// Shared definitions for the Rubik face colour classifier: geometry, FSM states,
// colour codes, classification thresholds and RGB565 field positions.
package classificador_cores_quadrante_pkg;

    localparam int LOG2_PIXELS  = 4;
    localparam int N_QUADRANTES = 9;
    localparam int ADDR_W       = 5 + LOG2_PIXELS;
    localparam int ACC_R_W      = 5 + LOG2_PIXELS;
    localparam int ACC_G_W      = 6 + LOG2_PIXELS;
    localparam int ACC_B_W      = 5 + LOG2_PIXELS;
    localparam int CORES_W      = 3 * N_QUADRANTES;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        ZERA      = 4'd1,
        PEDE_ALTO = 4'd2,
        LE_ALTO   = 4'd3,
        LE_BAIXO  = 4'd4,
        CALCULA   = 4'd5,
        EMITE     = 4'd6,
        FIM       = 4'd7
    } estado_t;

    localparam logic [2:0] COR_BRANCO     = 3'd0;
    localparam logic [2:0] COR_AMARELO    = 3'd1;
    localparam logic [2:0] COR_VERMELHO   = 3'd2;
    localparam logic [2:0] COR_LARANJA    = 3'd3;
    localparam logic [2:0] COR_VERDE      = 3'd4;
    localparam logic [2:0] COR_AZUL       = 3'd5;
    localparam logic [2:0] COR_INDEFINIDO = 3'd7;

    localparam logic [4:0] LIMIAR_ALTO     = 5'd20;
    localparam logic [4:0] LIMIAR_VERMELHO = 5'd16;
    localparam logic [4:0] LIMIAR_BAIXO    = 5'd10;
    localparam logic [5:0] MARGEM          = 6'd4;

    // High byte RRRRRGGG, low byte GGGBBBBB.
    localparam int HI_R_MSB = 7;
    localparam int HI_R_LSB = 3;
    localparam int HI_G_MSB = 2;
    localparam int LO_G_MSB = 7;
    localparam int LO_G_LSB = 5;
    localparam int LO_B_MSB = 4;

endpackage

// File: rtl/classificador_cores_quadrante_if.sv
// Control, buffer-memory and result signals of the face colour classifier.
interface classificador_cores_quadrante_if;
    import classificador_cores_quadrante_pkg::*;

    logic               iniciar;
    logic [7:0]         mem_dado;
    logic [ADDR_W-1:0]  mem_endereco;
    logic               mem_le;
    logic [2:0]         cor;
    logic [3:0]         quadrante;
    logic               cor_valida;
    logic [CORES_W-1:0] cores;
    logic               ocupado;
    logic               pronto;
    logic [3:0]         db_estado;

    modport master (
        output iniciar, mem_dado,
        input  mem_endereco, mem_le, cor, quadrante, cor_valida, cores,
               ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, mem_dado,
        output mem_endereco, mem_le, cor, quadrante, cor_valida, cores,
               ocupado, pronto, db_estado
    );

endinterface

// File: rtl/classificador_cores_quadrante_classifica_cor_rgb.sv
// Maps a 5/5/5-bit average colour to a Rubik colour code; first matching rule wins.
module classifica_cor_rgb
    import classificador_cores_quadrante_pkg::*;
(
    input  logic [4:0] r_i,
    input  logic [4:0] g_i,
    input  logic [4:0] b_i,
    output logic [2:0] cor_o
);

    // Margin comparisons need a sixth bit so that x+4 cannot wrap.
    logic [5:0] r6, g6, b6;
    assign r6 = {1'b0, r_i};
    assign g6 = {1'b0, g_i};
    assign b6 = {1'b0, b_i};

    always_comb begin
        cor_o = COR_INDEFINIDO;
        if (r_i >= LIMIAR_ALTO && g_i >= LIMIAR_ALTO && b_i >= LIMIAR_ALTO)
            cor_o = COR_BRANCO;
        else if (r_i >= LIMIAR_ALTO && g_i >= LIMIAR_ALTO)
            cor_o = COR_AMARELO;
        else if (r_i >= LIMIAR_VERMELHO && g_i < LIMIAR_BAIXO)
            cor_o = COR_VERMELHO;
        else if (r_i >= LIMIAR_ALTO && g_i < LIMIAR_ALTO)
            cor_o = COR_LARANJA;
        else if (g6 >= r6 + MARGEM && g6 >= b6 + MARGEM)
            cor_o = COR_VERDE;
        else if (b6 >= r6 + MARGEM && b_i >= g_i)
            cor_o = COR_AZUL;
    end

endmodule

// File: rtl/classificador_cores_quadrante.sv
// Reads the 9 quadrants of a captured face, averages each quadrant's RGB565 pixels
// and reports one colour code per quadrant plus the packed face result.
module classificador_cores_quadrante
    import classificador_cores_quadrante_pkg::*;
(
    input  logic clock,
    input  logic reset,
    classificador_cores_quadrante_if.slave bus
);

    localparam logic [LOG2_PIXELS-1:0] PIX_ULTIMO = '1;
    localparam logic [3:0]             QUAD_ULTIMO = 4'(N_QUADRANTES - 1);

    estado_t              estado_q, estado_d;
    logic [3:0]           quad_q, quad_d;
    logic [LOG2_PIXELS-1:0] pix_q, pix_d;
    logic [7:0]           alto_q, alto_d;
    logic [ACC_R_W-1:0]   acc_r_q, acc_r_d;
    logic [ACC_G_W-1:0]   acc_g_q, acc_g_d;
    logic [ACC_B_W-1:0]   acc_b_q, acc_b_d;
    logic [2:0]           cor_q, cor_d;
    logic [3:0]           quadrante_q, quadrante_d;
    logic [CORES_W-1:0]   cores_q, cores_d;

    logic [4:0] media_r, media_g, media_b;
    logic [2:0] cor_calc;
    logic       mem_le;

    // Green keeps 6 bits in the sum; the classifier sees its top 5 of the average.
    assign media_r = 5'(acc_r_q >> LOG2_PIXELS);
    assign media_g = 5'(acc_g_q >> (LOG2_PIXELS + 1));
    assign media_b = 5'(acc_b_q >> LOG2_PIXELS);

    classifica_cor_rgb u_classifica (
        .r_i   (media_r),
        .g_i   (media_g),
        .b_i   (media_b),
        .cor_o (cor_calc)
    );

    always_comb begin
        estado_d    = estado_q;
        quad_d      = quad_q;
        pix_d       = pix_q;
        alto_d      = alto_q;
        acc_r_d     = acc_r_q;
        acc_g_d     = acc_g_q;
        acc_b_d     = acc_b_q;
        cor_d       = cor_q;
        quadrante_d = quadrante_q;
        cores_d     = cores_q;
        case (estado_q)
            OCIOSO: if (bus.iniciar) estado_d = ZERA;
            ZERA: begin
                quad_d   = '0;
                pix_d    = '0;
                acc_r_d  = '0;
                acc_g_d  = '0;
                acc_b_d  = '0;
                estado_d = PEDE_ALTO;
            end
            PEDE_ALTO: estado_d = LE_ALTO;
            LE_ALTO: begin
                alto_d   = bus.mem_dado;
                estado_d = LE_BAIXO;
            end
            LE_BAIXO: begin
                acc_r_d = acc_r_q + ACC_R_W'(alto_q[HI_R_MSB:HI_R_LSB]);
                acc_g_d = acc_g_q + ACC_G_W'({alto_q[HI_G_MSB:0], bus.mem_dado[LO_G_MSB:LO_G_LSB]});
                acc_b_d = acc_b_q + ACC_B_W'(bus.mem_dado[LO_B_MSB:0]);
                if (pix_q == PIX_ULTIMO) begin
                    estado_d = CALCULA;
                end else begin
                    pix_d    = pix_q + LOG2_PIXELS'(1);
                    estado_d = PEDE_ALTO;
                end
            end
            // The code is registered on entry to EMITE so cor lines up with cor_valida.
            CALCULA: begin
                cor_d       = cor_calc;
                quadrante_d = quad_q;
                estado_d    = EMITE;
            end
            EMITE: begin
                for (int k = 0; k < N_QUADRANTES; k++)
                    if (quad_q == 4'(k)) cores_d[3*k +: 3] = cor_q;
                acc_r_d = '0;
                acc_g_d = '0;
                acc_b_d = '0;
                pix_d   = '0;
                if (quad_q == QUAD_ULTIMO) begin
                    estado_d = FIM;
                end else begin
                    quad_d   = quad_q + 4'd1;
                    estado_d = PEDE_ALTO;
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            quad_q      <= '0;
            pix_q       <= '0;
            alto_q      <= '0;
            acc_r_q     <= '0;
            acc_g_q     <= '0;
            acc_b_q     <= '0;
            cor_q       <= '0;
            quadrante_q <= '0;
            cores_q     <= '0;
        end else begin
            estado_q    <= estado_d;
            quad_q      <= quad_d;
            pix_q       <= pix_d;
            alto_q      <= alto_d;
            acc_r_q     <= acc_r_d;
            acc_g_q     <= acc_g_d;
            acc_b_q     <= acc_b_d;
            cor_q       <= cor_d;
            quadrante_q <= quadrante_d;
            cores_q     <= cores_d;
        end
    end

    assign mem_le           = (estado_q == PEDE_ALTO) || (estado_q == LE_ALTO);
    assign bus.mem_le       = mem_le;
    assign bus.mem_endereco = mem_le ? {quad_q, pix_q, estado_q == LE_ALTO} : '0;
    assign bus.cor          = cor_q;
    assign bus.quadrante    = quadrante_q;
    assign bus.cor_valida   = (estado_q == EMITE);
    assign bus.cores        = cores_q;
    assign bus.ocupado      = (estado_q != OCIOSO);
    assign bus.pronto       = (estado_q == FIM);
    assign bus.db_estado    = estado_q;

endmodule
